// File: rtl/if_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// if_stage : RV32I instruction fetch with IF/ID register, stall, redirect
// Rev 1.0
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_inst,
  output logic        id_fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [0:0] {
    S_RUN  = 1'b0,
    S_HALT = 1'b1
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_target;

  assign w_pc_plus4 = r_pc + 32'd4;
  // Bit 0 is dropped as JALR does; bit 1 still flags a misaligned word.
  assign w_target   = {redirect_pc[31:1], 1'b0};
  assign imem_addr  = r_pc[31:2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_pc        <= RESET_PC;
      id_valid    <= 1'b0;
      id_pc       <= 32'd0;
      id_pc_plus4 <= 32'd0;
      id_inst     <= NOP_INST;
      id_fault    <= 1'b0;
      fetch_count <= 32'd0;
    end else if (redirect_valid) begin
      r_pc        <= w_target;
      id_valid    <= 1'b0;
      id_pc       <= 32'd0;
      id_pc_plus4 <= 32'd0;
      id_inst     <= NOP_INST;
      if (w_target[1]) begin
        id_fault <= 1'b1;
        r_state  <= S_HALT;
      end else begin
        id_fault <= 1'b0;
        r_state  <= S_RUN;
      end
    end else if (r_state == S_RUN && !stall) begin
      r_pc        <= w_pc_plus4;
      id_valid    <= 1'b1;
      id_pc       <= r_pc;
      id_pc_plus4 <= w_pc_plus4;
      id_inst     <= imem_data;
      fetch_count <= fetch_count + 32'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_if_stage : directed self-checking bench for if_stage
// ---------------------------------------------------------------------------
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] imem_addr;
  logic [31:0] imem_data;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus4;
  logic [31:0] id_inst;
  logic        id_fault;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instruction memory: word k holds k+100.
  assign imem_data = {2'b00, imem_addr} + 32'd100;

  if_stage dut (
    .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_data(imem_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
    .id_inst(id_inst), .id_fault(id_fault), .fetch_count(fetch_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0h exp 0", id_valid); end
    checks++; if (id_inst !== 32'h13) begin errors++; $display("FAIL reset_inst got %0h exp 13", id_inst); end
    checks++; if (id_pc !== 32'd0 || id_pc_plus4 !== 32'd0) begin errors++; $display("FAIL reset_pc got %0h/%0h exp 0/0", id_pc, id_pc_plus4); end
    checks++; if (id_fault !== 1'b0 || fetch_count !== 32'd0) begin errors++; $display("FAIL reset_fault_cnt got %0h/%0h exp 0/0", id_fault, fetch_count); end
    checks++; if (imem_addr !== 30'd0) begin errors++; $display("FAIL reset_imem_addr got %0h exp 0", imem_addr); end
  endtask

  task automatic test_freerun();
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'd0 || id_inst !== 32'd100) begin errors++; $display("FAIL run_edge1 got v=%0h pc=%0h inst=%0d exp 1/0/100", id_valid, id_pc, id_inst); end
    tick(); tick();
    checks++; if (id_pc !== 32'd8 || id_pc_plus4 !== 32'd12) begin errors++; $display("FAIL run_pc got %0h/%0h exp 8/c", id_pc, id_pc_plus4); end
    checks++; if (id_inst !== 32'd102 || fetch_count !== 32'd3) begin errors++; $display("FAIL run_inst_cnt got %0d/%0d exp 102/3", id_inst, fetch_count); end
    checks++; if (imem_addr !== 30'd3) begin errors++; $display("FAIL run_imem_addr got %0h exp 3", imem_addr); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    checks++; if (id_pc !== 32'd4 || fetch_count !== 32'd2) begin errors++; $display("FAIL stall_pre got %0h/%0d exp 4/2", id_pc, fetch_count); end
    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if (id_pc !== 32'd4 || fetch_count !== 32'd2 || id_inst !== 32'd101 || imem_addr !== 30'd2) begin
        errors++; $display("FAIL stall_hold%0d got pc=%0h cnt=%0d inst=%0d ia=%0h exp 4/2/101/2", i, id_pc, fetch_count, id_inst, imem_addr);
      end
    end
    stall = 1'b0;
    tick();
    checks++; if (id_pc !== 32'd8 || fetch_count !== 32'd3 || id_inst !== 32'd102) begin errors++; $display("FAIL stall_resume got %0h/%0d/%0d exp 8/3/102", id_pc, fetch_count, id_inst); end
  endtask

  task automatic test_redirect_with_stall();
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
    tick();
    stall = 1'b0; redirect_valid = 1'b0;
    checks++; if (id_valid !== 1'b0 || id_inst !== 32'h13 || id_pc !== 32'd0 || id_pc_plus4 !== 32'd0) begin
      errors++; $display("FAIL redir_bubble got v=%0h inst=%0h pc=%0h/%0h exp 0/13/0/0", id_valid, id_inst, id_pc, id_pc_plus4);
    end
    checks++; if (imem_addr !== 30'h10 || fetch_count !== 32'd3) begin errors++; $display("FAIL redir_addr got %0h/%0d exp 10/3", imem_addr, fetch_count); end
    tick();
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h40 || id_inst !== 32'd116 || fetch_count !== 32'd4) begin
      errors++; $display("FAIL redir_target got v=%0h pc=%0h inst=%0d cnt=%0d exp 1/40/116/4", id_valid, id_pc, id_inst, fetch_count);
    end
  endtask

  task automatic test_fault_halt();
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    tick();
    redirect_valid = 1'b0;
    checks++; if (id_fault !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 30'h10) begin
      errors++; $display("FAIL fault_enter got f=%0h v=%0h ia=%0h exp 1/0/10", id_fault, id_valid, imem_addr);
    end
    for (int i = 0; i < 5; i++) begin
      stall = (i % 2 == 0);
      tick();
      checks++; if (id_fault !== 1'b1 || id_valid !== 1'b0 || imem_addr !== 30'h10 || fetch_count !== 32'd4 || id_inst !== 32'h13) begin
        errors++; $display("FAIL halt_hold%0d got f=%0h v=%0h ia=%0h cnt=%0d inst=%0h exp 1/0/10/4/13", i, id_fault, id_valid, imem_addr, fetch_count, id_inst);
      end
    end
    stall = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 32'h46;
    tick();
    checks++; if (id_fault !== 1'b1 || imem_addr !== 30'h11) begin errors++; $display("FAIL halt_reredirect got f=%0h ia=%0h exp 1/11", id_fault, imem_addr); end
    redirect_pc = 32'h80;
    tick();
    redirect_valid = 1'b0;
    checks++; if (id_fault !== 1'b0 || id_valid !== 1'b0 || imem_addr !== 30'h20) begin
      errors++; $display("FAIL fault_clear got f=%0h v=%0h ia=%0h exp 0/0/20", id_fault, id_valid, imem_addr);
    end
    tick();
    checks++; if (id_pc !== 32'h80 || id_valid !== 1'b1 || fetch_count !== 32'd5) begin errors++; $display("FAIL fault_resume got pc=%0h v=%0h cnt=%0d exp 80/1/5", id_pc, id_valid, fetch_count); end
  endtask

  task automatic test_bit0_clear();
    redirect_valid = 1'b1; redirect_pc = 32'h41;
    tick();
    redirect_valid = 1'b0;
    checks++; if (id_fault !== 1'b0 || imem_addr !== 30'h10) begin errors++; $display("FAIL bit0_redir got f=%0h ia=%0h exp 0/10", id_fault, imem_addr); end
    tick();
    checks++; if (id_pc !== 32'h40 || id_pc_plus4 !== 32'h44 || fetch_count !== 32'd6) begin
      errors++; $display("FAIL bit0_target got pc=%0h p4=%0h cnt=%0d exp 40/44/6", id_pc, id_pc_plus4, fetch_count);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    tick();
    checks++; if (id_pc !== 32'hFFFF_FFFC || id_pc_plus4 !== 32'd0 || id_inst !== 32'h4000_0063) begin
      errors++; $display("FAIL wrap_top got pc=%0h p4=%0h inst=%0h exp fffffffc/0/40000063", id_pc, id_pc_plus4, id_inst);
    end
    tick();
    checks++; if (id_pc !== 32'd0 || id_inst !== 32'd100 || fetch_count !== 32'd8) begin
      errors++; $display("FAIL wrap_zero got pc=%0h inst=%0d cnt=%0d exp 0/100/8", id_pc, id_inst, fetch_count);
    end
  endtask

  task automatic test_async_reset();
    tick(); tick();
    #2 rst = 1'b1;
    #1;
    checks++; if (id_valid !== 1'b0 || id_inst !== 32'h13 || id_pc !== 32'd0 || id_pc_plus4 !== 32'd0 || id_fault !== 1'b0 || fetch_count !== 32'd0 || imem_addr !== 30'd0) begin
      errors++; $display("FAIL async_reset got v=%0h inst=%0h pc=%0h p4=%0h f=%0h cnt=%0d ia=%0h exp all reset", id_valid, id_inst, id_pc, id_pc_plus4, id_fault, fetch_count, imem_addr);
    end
    tick();
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_freerun();
    test_stall();
    test_redirect_with_stall();
    test_fault_halt();
    test_bit0_clear();
    test_wrap();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
